// File: rtl/rca_pipe_if.sv
// Stream interface of rca_pipe: operand channel in, sum channel out.
// The ovf signal exists only when RCA_PIPE_OVF_EN is defined.
interface rca_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef RCA_PIPE_OVF_EN
  logic             ovf;
`endif

  // Adder side
  modport slave (
    input  in_valid, A, B, c_in, out_ready,
    output in_ready, out_valid, sum, c_out
`ifdef RCA_PIPE_OVF_EN
    , output ovf
`endif
  );

  // Producer/consumer side
  modport master (
    output in_valid, A, B, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out
`ifdef RCA_PIPE_OVF_EN
    , input ovf
`endif
  );
endinterface

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder: sum = A + B + c_in, split into STAGES slices
// of WIDTH/STAGES bits, one ripple chain per stage, valid/ready stream.
// Optional feature macro: RCA_PIPE_OVF_EN adds the registered signed-overflow output ovf.
module rca_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  rca_pipe_if.slave ifc
);
  localparam int unsigned SLICE = WIDTH / STAGES;

  logic adv_c;
  logic out_valid_w;

  // Global advance: the whole pipe moves unless a result is stuck at the output
  assign adv_c        = !out_valid_w || ifc.out_ready;
  assign ifc.in_ready = adv_c;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // REM: operand bits still to be added on entry; LOW: sum bits already produced
    localparam int unsigned REM = WIDTH - 32'(k) * SLICE;
    localparam int unsigned LOW = 32'(k) * SLICE;

    logic                   v_in;
    logic [REM-1:0]         a_in;
    logic [REM-1:0]         b_in;
    logic                   c_in_w;
    logic [SLICE-1:0]       sl;
    logic                   cr;
    logic [SLICE-1:0]       ta;
    logic [SLICE-1:0]       tb;
    logic [LOW+SLICE-1:0]   s_new;
    logic                   v_q, v_d;
    logic                   c_q, c_d;
    logic [LOW+SLICE-1:0]   s_q, s_d;

    // Stage source: ports for the first stage, previous stage registers otherwise
    if (k == 0) begin : g_src
      assign v_in   = ifc.in_valid;
      assign a_in   = ifc.A;
      assign b_in   = ifc.B;
      assign c_in_w = ifc.c_in;
    end else begin : g_src
      assign v_in   = g_stage[k-1].v_q;
      assign a_in   = g_stage[k-1].g_fwd.a_q;
      assign b_in   = g_stage[k-1].g_fwd.b_q;
      assign c_in_w = g_stage[k-1].c_q;
    end

    // Ripple chain of SLICE full adders over the low slice of the remaining operands
    always_comb begin
      ta = a_in[SLICE-1:0];
      tb = b_in[SLICE-1:0];
      cr = c_in_w;
      sl = '0;
      for (int i = 0; i < SLICE; i++) begin
        sl            = sl >> 1;
        sl[SLICE-1]   = ta[0] ^ tb[0] ^ cr;
        cr            = (ta[0] & tb[0]) | (cr & (ta[0] ^ tb[0]));
        ta            = ta >> 1;
        tb            = tb >> 1;
      end
    end

    // New slice lands above the already-computed lower sum bits
    if (k == 0) begin : g_sum
      always_comb s_new = sl;
    end else begin : g_sum
      always_comb s_new = {sl, g_stage[k-1].s_q};
    end

    // Stage next-state: hold on stall, data only replaced by a valid slot
    always_comb begin
      v_d = v_q;
      c_d = c_q;
      s_d = s_q;
      if (adv_c) begin
        v_d = v_in;
        if (v_in) begin
          c_d = cr;
          s_d = s_new;
        end
      end
    end

    // Stage valid, carry and partial sum registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    // Delay line carrying the not-yet-added operand slices to the next stage
    if (k < STAGES - 1) begin : g_fwd
      logic [REM-SLICE-1:0] a_q, a_d;
      logic [REM-SLICE-1:0] b_q, b_d;

      // Forwarded operands advance with their slot
      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (adv_c && v_in) begin
          a_d = a_in[REM-1:SLICE];
          b_d = b_in[REM-1:SLICE];
        end
      end

      // Forwarded operand registers
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

`ifdef RCA_PIPE_OVF_EN
    if (k == STAGES - 1) begin : g_ovf
      logic ovf_q, ovf_d;

      // Carry into the MSB is recovered as a ^ b ^ s at that bit
      always_comb begin
        ovf_d = ovf_q;
        if (adv_c && v_in) begin
          ovf_d = (a_in[REM-1] ^ b_in[REM-1] ^ sl[SLICE-1]) ^ cr;
        end
      end

      // Overflow register, aligned with sum/c_out
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else begin
          ovf_q <= ovf_d;
        end
      end
    end
`endif
  end

  assign out_valid_w   = g_stage[STAGES-1].v_q;
  assign ifc.out_valid = out_valid_w;
  assign ifc.sum       = g_stage[STAGES-1].s_q;
  assign ifc.c_out     = g_stage[STAGES-1].c_q;
`ifdef RCA_PIPE_OVF_EN
  assign ifc.ovf       = g_stage[STAGES-1].g_ovf.ovf_q;
`endif
endmodule
